// File: rtl/aes_sbox.sv
// aes_sbox: registered FIPS-197 forward S-box applied independently to NUM byte lanes
module aes_sbox #(
  parameter int NUM = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [8*NUM-1:0] data_in,
  output logic             out_valid,
  output logic [8*NUM-1:0] data_out
);
  // Row-major FIPS-197 table: entry 00 sits in the top byte, entry ff in the bottom byte
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  logic [8*NUM-1:0] w_sub;
  logic [8*NUM-1:0] r_data;
  logic             r_valid;

  for (genvar i = 0; i < NUM; i++) begin : g_lane
    assign w_sub[8*i +: 8] = sbox(data_in[8*i +: 8]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_data  <= w_sub;
      r_valid <= in_valid;
    end
  end

  assign data_out  = r_data;
  assign out_valid = r_valid;
endmodule

// File: tb/tb_aes_sbox.sv
// tb_aes_sbox: checks NUM=1/2/4 instances against an S-box computed from GF(2^8) inversion plus the affine map
module tb_aes_sbox;
  logic        clk;
  logic        rst_n;
  logic        v1, v2, v4;
  logic [7:0]  d1;
  logic [15:0] d2;
  logic [31:0] d4;
  logic        ov1, ov2, ov4;
  logic [7:0]  q1;
  logic [15:0] q2;
  logic [31:0] q4;
  logic [7:0]  model [256];
  int          n_chk = 0;
  int          n_fail = 0;

  aes_sbox #(.NUM(1)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(v1), .data_in(d1), .out_valid(ov1), .data_out(q1));
  aes_sbox #(.NUM(2)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(v2), .data_in(d2), .out_valid(ov2), .data_out(q2));
  aes_sbox #(.NUM(4)) u4 (.clk(clk), .rst_n(rst_n), .in_valid(v4), .data_in(d4), .out_valid(ov4), .data_out(q4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] ref_s(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] x, input int n);
    logic [31:0] r = '0;
    for (int k = 0; k < n; k++) r[8*k +: 8] = model[x[8*k +: 8]];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 256; k++) model[k] = ref_s(8'(k));
    rst_n = 1'b0;
    v1 = 1'b1; v2 = 1'b1; v4 = 1'b1;
    d1 = 8'hff; d2 = 16'hffff; d4 = 32'hffffffff;
    tick; tick;
    check("rst_q1", 32'(q1), 32'h0);
    check("rst_v1", 32'(ov1), 32'h0);
    check("rst_q2", 32'(q2), 32'h0);
    check("rst_q4", q4, 32'h0);
    check("rst_v4", 32'(ov4), 32'h0);
    rst_n = 1'b1;
    tick;
    check("post_rst_q1", 32'(q1), 32'h16);
    check("post_rst_v1", 32'(ov1), 32'h1);

    d1 = 8'h00;
    tick;
    check("s00", 32'(q1), 32'h63);
    d1 = 8'h4f;
    #2;
    check("latency_hold", 32'(q1), 32'h63);
    tick;
    check("s4f", 32'(q1), 32'h84);

    d2 = 16'hff80;
    tick;
    check("lanes_ff80", 32'(q2), 32'h16cd);
    d2 = 16'h2f8d;
    tick;
    check("lanes_2f8d", 32'(q2), 32'h155d);

    foreach (d1[k]) ;
    for (int k = 0; k < 256; k++) begin
      d1 = 8'(k);
      tick;
      check($sformatf("sweep_%02h", k), 32'(q1), 32'(model[k]));
      check("sweep_valid", 32'(ov1), 32'h1);
    end
    d1 = 8'h53; tick; check("spot_53", 32'(q1), 32'hed);
    d1 = 8'h01; tick; check("spot_01", 32'(q1), 32'h7c);
    d1 = 8'h10; tick; check("spot_10", 32'(q1), 32'hca);

    for (int k = 0; k < 300; k++) begin
      d1 = 8'($urandom); d2 = 16'($urandom); d4 = $urandom;
      v1 = 1'($urandom_range(0, 1)); v2 = 1'($urandom_range(0, 1)); v4 = 1'($urandom_range(0, 1));
      tick;
      check("rnd_q1", 32'(q1), ref_word(32'(d1), 1));
      check("rnd_q2", 32'(q2), ref_word(32'(d2), 2));
      check("rnd_q4", q4, ref_word(d4, 4));
      check("rnd_v", {29'h0, ov4, ov2, ov1}, {29'h0, v4, v2, v1});
    end

    v4 = 1'b1;
    d4 = 32'h00010203;
    tick;
    check("pre_async_q4", q4, 32'h637c777b);
    #2 rst_n = 1'b0;
    #1;
    check("async_q4", q4, 32'h0);
    check("async_v4", 32'(ov4), 32'h0);
    tick;
    check("held_rst_q4", q4, 32'h0);
    rst_n = 1'b1;
    tick;
    check("after_async_q4", q4, 32'h637c777b);
    check("after_async_v4", 32'(ov4), 32'h1);

    v1 = 1'b1; d1 = 8'h11; tick;
    check("gate1_v", 32'(ov1), 32'h1);
    check("gate1_q", 32'(q1), 32'h82);
    v1 = 1'b0; d1 = 8'h22; tick;
    check("gate0_v", 32'(ov1), 32'h0);
    check("gate0_q", 32'(q1), 32'h93);
    v1 = 1'b1; d1 = 8'h33; tick;
    check("gate2_v", 32'(ov1), 32'h1);
    check("gate2_q", 32'(q1), 32'hc3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_sbox.md
Name: aes_sbox

Overview:
- Forward AES SubBytes substitution box (FIPS-197 S-box) applied in parallel to NUM independent bytes.
- Used as the byte-substitution stage of the AES round datapath and the key-expansion SubWord step (NUM=4).
- Output is registered: one clock of latency, with a valid flag carried alongside the data.

Parameters:
- NUM, default 1: number of bytes substituted in parallel. Legal range 1..16. Data width is 8*NUM.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  data_in is valid this cycle.
- data_in  input  8*NUM  bytes to substitute; byte i occupies bits [8i+7:8i].
- out_valid  output  1  data_out holds a substitution result.
- data_out  output  8*NUM  substituted bytes; byte i occupies bits [8i+7:8i].

Behaviour:
- Mapping: for every byte lane i, data_out[8i+7:8i] = S(data_in[8i+7:8i]), where S is the standard 256-entry forward AES S-box.
  - Lanes are fully independent; there is no cross-lane interaction or byte reordering.
  - Lane 0 is the least-significant byte.
- Implementation: a single shared 256-entry constant lookup function or case table, instantiated once per lane via generate.
  - The table must match FIPS-197 exactly in all 256 entries.
  - Examples: S(00)=63, S(01)=7c, S(53)=ed, S(ff)=16.
- Timing: purely registered output.
  - On each rising clk edge, data_out <= S(data_in) lane-wise and out_valid <= in_valid.
  - Latency is exactly 1 cycle; throughput is one word per cycle.
  - No stall or backpressure.
- data_out updates every cycle regardless of in_valid; consumers qualify it with out_valid.
- Reset: asserting rst_n low immediately (asynchronously) forces data_out to all-zeros and out_valid to 0.
  - Reset mid-stream discards the in-flight word.
  - After rst_n deasserts, the first edge captures the current inputs normally.
- No X propagation from the table: every 8-bit input value has a defined entry.
- Inverse S-box is out of scope.

Test Plan:
- Reset: hold rst_n=0 and drive data_in=ff -> data_out=00, out_valid=0. Release reset, in_valid=1, one clk -> data_out=16, out_valid=1.
- NUM=1 directed: drive 00 -> 63 after one edge; drive 4f -> 84 after the next edge; confirm the 1-cycle latency alignment of out_valid.
- NUM=2 lane ordering: ff80 -> 16cd; then 2f8d -> 155d on back-to-back cycles, each result appearing exactly one cycle after its input.
- Exhaustive: NUM=1, sweep 00..ff with in_valid=1 -> every output matches a golden FIPS-197 table. Spot checks: 53->ed, 01->7c, 10->ca.
- Async reset mid-stream: NUM=4, stream 00010203 then assert rst_n low between edges -> outputs clear immediately without a clock. After release, 00010203 -> 637c777b.
- Valid gating: in_valid toggles 1,0,1 -> out_valid follows 1,0,1 delayed one cycle. data_out still tracks S(data_in) every cycle.
